// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit with a handshaked AR/R/AW/W master.
// Accepts one access at a time from the pipeline. It checks alignment and
// support, drives a line-wide bus, and returns one resp_valid pulse per access.
//   clk, rst                    : clock, synchronous active-high reset
//   req_*                       : pipeline request (valid/ready, write, funct3, addr, wdata, rd)
//   resp_*                      : completion pulse, error flag, extended load data, rd echo, write-enable
//   ARADDR/ARVALID/ARREADY      : read address channel (line-aligned)
//   RDATA/RVALID/RREADY         : read data channel
//   AWADDR/AWVALID/AWREADY      : write address channel (line-aligned)
//   WDATA/WSTRB/WVALID/WREADY   : write data channel with per-byte strobes
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  localparam int STRB_W = LINE_W / 8,
  localparam int OFF_W  = $clog2(LINE_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_we,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [LINE_W-1:0] RDATA,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [LINE_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  output logic              WVALID,
  input  logic              WREADY
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, RESP} state_e;

  state_e             state_q, state_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [4:0]         rd_q, rd_d;
  logic [ADDR_W-1:0]  araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]  wstrb_q, wstrb_d;
  logic               arvalid_q, arvalid_d, rready_q, rready_d;
  logic               awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic               req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d, resp_we_q, resp_we_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic [4:0]         resp_rd_q, resp_rd_d;

  logic               accept, unsupported, misaligned;
  logic [3:0]         size_mask;
  logic [ADDR_W-1:0]  line_addr;
  logic [31:0]        rword, load_val;

  always_comb begin
    accept = req_valid & req_ready_q;

    if (req_write) unsupported = (req_funct3 >= 3'd3);
    else           unsupported = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) ||
                                 (req_funct3 == 3'd7);

    unique case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase

    unique case (req_funct3[1:0])
      2'b00:   size_mask = 4'h1;
      2'b01:   size_mask = 4'h3;
      default: size_mask = 4'hF;
    endcase

    line_addr = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Bring the addressed byte down to bit 0; alignment keeps the word inside the line.
    rword = 32'(RDATA >> {off_q, 3'b000});
    unique case (funct3_q)
      3'd0:    load_val = {{24{rword[7]}}, rword[7:0]};
      3'd1:    load_val = {{16{rword[15]}}, rword[15:0]};
      3'd4:    load_val = {24'h0, rword[7:0]};
      3'd5:    load_val = {16'h0, rword[15:0]};
      default: load_val = rword;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    funct3_d     = funct3_q;
    rd_d         = rd_q;
    araddr_d     = araddr_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    resp_err_d   = resp_err_q;
    resp_we_d    = resp_we_q;
    resp_rdata_d = resp_rdata_q;
    resp_rd_d    = resp_rd_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          off_d    = req_addr[OFF_W-1:0];
          funct3_d = req_funct3;
          rd_d     = req_rd;
          if (unsupported || misaligned) begin
            state_d      = RESP;
            resp_err_d   = 1'b1;
            resp_we_d    = 1'b0;
            resp_rdata_d = '0;
            resp_rd_d    = req_rd;
          end else if (req_write) begin
            state_d   = WR;
            awaddr_d  = line_addr;
            wdata_d   = LINE_W'(req_wdata) << {req_addr[OFF_W-1:0], 3'b000};
            wstrb_d   = STRB_W'(size_mask) << req_addr[OFF_W-1:0];
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d  = RD_ADDR;
            araddr_d = line_addr;
          end
        end
      end
      RD_ADDR: if (ARREADY) state_d = RD_DATA;
      RD_DATA: begin
        if (RVALID) begin
          state_d      = RESP;
          resp_err_d   = 1'b0;
          resp_we_d    = 1'b1;
          resp_rdata_d = load_val;
          resp_rd_d    = rd_q;
        end
      end
      WR: begin
        // AW and W retire independently; leave once neither is still pending.
        if (AWREADY) awvalid_d = 1'b0;
        if (WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d      = RESP;
          resp_err_d   = 1'b0;
          resp_we_d    = 1'b0;
          resp_rdata_d = '0;
          resp_rd_d    = rd_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d  = (state_d == IDLE);
    arvalid_d    = (state_d == RD_ADDR);
    rready_d     = (state_d == RD_DATA);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      off_q        <= '0;
      funct3_q     <= '0;
      rd_q         <= '0;
      araddr_q     <= '0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_rdata_q <= '0;
      resp_rd_q    <= '0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      funct3_q     <= funct3_d;
      rd_q         <= rd_d;
      araddr_q     <= araddr_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_we_q    <= resp_we_d;
      resp_rdata_q <= resp_rdata_d;
      resp_rd_q    <= resp_rd_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_rd    = resp_rd_q;
  assign resp_we    = resp_we_q;
  assign ARADDR     = araddr_q;
  assign ARVALID    = arvalid_q;
  assign RREADY     = rready_q;
  assign AWADDR     = awaddr_q;
  assign AWVALID    = awvalid_q;
  assign WDATA      = wdata_q;
  assign WSTRB      = wstrb_q;
  assign WVALID     = wvalid_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit with LINE_W = 128.
module tb_mem_access_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_write;
  logic [2:0]   req_funct3;
  logic [31:0]  req_addr, req_wdata;
  logic [4:0]   req_rd;
  logic         resp_valid, resp_err, resp_we;
  logic [31:0]  resp_rdata;
  logic [4:0]   resp_rd;
  logic [31:0]  ARADDR, AWADDR;
  logic         ARVALID, ARREADY, RVALID, RREADY, AWVALID, AWREADY, WVALID, WREADY;
  logic [127:0] RDATA, WDATA;
  logic [15:0]  WSTRB;

  int n_cmp = 0;
  int n_fail = 0;

  mem_access_unit #(.ADDR_W(32), .LINE_W(128)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_we(resp_we),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         write;
    logic [2:0]   f3;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic         err;
    logic [31:0]  rdata;
    logic [31:0]  baddr;
    logic [15:0]  strb;
    logic [127:0] wline;
  } vec_t;

  localparam logic [127:0] LINE = 128'h80112233_44556677_8899AABB_CCDDEEFF;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] rd);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_rd     = rd;
  endtask

  // Zero-wait slave: all readies high, RVALID high with LINE throughout.
  task automatic run_vec(input vec_t v, input logic [4:0] rd);
    int  cyc, exp_lat, n_ar, n_aw, n_w;
    bit  got;
    exp_lat = v.err ? 1 : (v.write ? 2 : 3);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    drive_req(v.write, v.f3, v.addr, v.wdata, rd);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; got = 0; n_ar = 0; n_aw = 0; n_w = 0;
    while (!got && cyc <= 12) begin
      if (ARVALID) begin n_ar++; chk("araddr", ARADDR, v.baddr); end
      if (AWVALID) begin n_aw++; chk("awaddr", AWADDR, v.baddr); end
      if (WVALID) begin
        n_w++;
        chk("wdata", WDATA, v.wline);
        chk("wstrb", WSTRB, v.strb);
      end
      chk("req_ready_busy", req_ready, 1'b0);
      if (resp_valid) begin
        got = 1;
        chk("latency", cyc, exp_lat);
        chk("resp_err", resp_err, v.err);
        chk("resp_we", resp_we, !v.err && !v.write);
        chk("resp_rd", resp_rd, rd);
        if (!v.err && !v.write) chk("resp_rdata", resp_rdata, v.rdata);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("resp_seen", got, 1'b1);
    chk("ar_count", n_ar, (!v.err && !v.write) ? 1 : 0);
    chk("aw_count", n_aw, (!v.err && v.write) ? 1 : 0);
    chk("w_count", n_w, (!v.err && v.write) ? 1 : 0);
    @(negedge clk);
    chk("resp_pulse_end", resp_valid, 1'b0);
    chk("req_ready_back", req_ready, 1'b1);
    if (!v.err && !v.write) chk("resp_rdata_hold", resp_rdata, v.rdata);
  endtask

  vec_t vecs[20];

  initial begin
    vecs[0]  = '{1, 2, 'h104,  'hDEADBEEF, 0, 0, 'h100,  'h00F0, 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0000};
    vecs[1]  = '{0, 0, 'h10F,  0, 0, 'hFFFFFF80, 'h100, 0, 0};
    vecs[2]  = '{0, 4, 'h10F,  0, 0, 'h00000080, 'h100, 0, 0};
    vecs[3]  = '{0, 1, 'h203,  0, 1, 0, 0, 0, 0};
    vecs[4]  = '{0, 1, 'h206,  0, 0, 'hFFFF8899, 'h200, 0, 0};
    vecs[5]  = '{0, 5, 'h20A,  0, 0, 'h00004455, 'h200, 0, 0};
    vecs[6]  = '{0, 2, 'h30C,  0, 0, 'h80112233, 'h300, 0, 0};
    vecs[7]  = '{0, 2, 'h302,  0, 1, 0, 0, 0, 0};
    vecs[8]  = '{1, 0, 'h1003, 'h123456AB, 0, 0, 'h1000, 'h0008, 128'h0000_0000_0000_0000_0012_3456_AB00_0000};
    vecs[9]  = '{1, 1, 'h40E,  'hCAFE1234, 0, 0, 'h400,  'hC000, 128'h1234_0000_0000_0000_0000_0000_0000_0000};
    vecs[10] = '{1, 1, 'h401,  'h11111111, 1, 0, 0, 0, 0};
    vecs[11] = '{1, 3, 'h100,  'h11111111, 1, 0, 0, 0, 0};
    vecs[12] = '{1, 4, 'h100,  'h11111111, 1, 0, 0, 0, 0};
    vecs[13] = '{0, 3, 'h100,  0, 1, 0, 0, 0, 0};
    vecs[14] = '{0, 6, 'h100,  0, 1, 0, 0, 0, 0};
    vecs[15] = '{0, 7, 'h100,  0, 1, 0, 0, 0, 0};
    vecs[16] = '{0, 0, 'h500,  0, 0, 'hFFFFFFFF, 'h500, 0, 0};
    vecs[17] = '{0, 5, 'h500,  0, 0, 'h0000EEFF, 'h500, 0, 0};
    vecs[18] = '{0, 1, 'h10E,  0, 0, 'hFFFF8011, 'h100, 0, 0};
    vecs[19] = '{1, 2, 'h10C,  'h01020304, 0, 0, 'h100,  'hF000, 128'h0102_0304_0000_0000_0000_0000_0000_0000};

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
    ARREADY = 1'b1; AWREADY = 1'b1; WREADY = 1'b1; RVALID = 1'b1; RDATA = LINE;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_arvalid", ARVALID, 1'b0);
    chk("rst_rready", RREADY, 1'b0);
    chk("rst_awvalid", AWVALID, 1'b0);
    chk("rst_wvalid", WVALID, 1'b0);
    chk("rst_wstrb", WSTRB, 16'h0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_resp_we", resp_we, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);

    for (int i = 0; i < 20; i++) run_vec(vecs[i], 5'(i + 1));

    // Store with W stalled three cycles after AW is taken.
    AWREADY = 1'b1; WREADY = 1'b0;
    @(negedge clk);
    drive_req(1'b1, 3'd2, 32'h8, 32'hA5A55A5A, 5'd3);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("seqA_awvalid", AWVALID, k == 1);
      chk("seqA_wvalid", WVALID, 1'b1);
      chk("seqA_wdata", WDATA, 128'h0000_0000_A5A5_5A5A_0000_0000_0000_0000);
      chk("seqA_wstrb", WSTRB, 16'h0F00);
      chk("seqA_req_ready", req_ready, 1'b0);
      chk("seqA_no_resp", resp_valid, 1'b0);
      if (k == 4) WREADY = 1'b1;
      @(negedge clk);
    end
    chk("seqA_resp", resp_valid, 1'b1);
    chk("seqA_wvalid_drop", WVALID, 1'b0);
    chk("seqA_err", resp_err, 1'b0);
    chk("seqA_we", resp_we, 1'b0);
    chk("seqA_req_ready_resp", req_ready, 1'b0);

    // Load with delayed ARREADY and RVALID.
    @(negedge clk);
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = 128'hFFFF_0000_AAAA_5555_0F0F_F0F0_1234_5678;
    drive_req(1'b0, 3'd2, 32'h20, 32'h0, 5'd17);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk("seqB_arvalid", ARVALID, 1'b1);
      chk("seqB_araddr", ARADDR, 32'h20);
      chk("seqB_rready_low", RREADY, 1'b0);
      if (k == 3) ARREADY = 1'b1;
      @(negedge clk);
    end
    for (int k = 1; k <= 4; k++) begin
      chk("seqB_rready", RREADY, 1'b1);
      chk("seqB_arvalid_low", ARVALID, 1'b0);
      chk("seqB_no_resp", resp_valid, 1'b0);
      if (k == 4) RVALID = 1'b1;
      @(negedge clk);
    end
    chk("seqB_resp", resp_valid, 1'b1);
    chk("seqB_rdata", resp_rdata, 32'h12345678);
    chk("seqB_rd", resp_rd, 5'd17);
    chk("seqB_we", resp_we, 1'b1);
    chk("seqB_err", resp_err, 1'b0);

    // Reset while waiting in RD_DATA abandons the load.
    @(negedge clk);
    RVALID = 1'b0; ARREADY = 1'b1; RDATA = LINE;
    drive_req(1'b0, 3'd0, 32'h40, 32'h0, 5'd9);
    @(negedge clk);
    req_valid = 1'b0;
    chk("seqC_arvalid", ARVALID, 1'b1);
    @(negedge clk);
    chk("seqC_rready", RREADY, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("seqC_arvalid_rst", ARVALID, 1'b0);
    chk("seqC_rready_rst", RREADY, 1'b0);
    chk("seqC_resp_valid_rst", resp_valid, 1'b0);
    chk("seqC_req_ready_rst", req_ready, 1'b1);
    chk("seqC_resp_we_rst", resp_we, 1'b0);
    RVALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("seqC_no_resp", resp_valid, 1'b0);
      chk("seqC_rready_idle", RREADY, 1'b0);
    end
    RVALID = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
